// File: rtl/flatten_three_serializer.sv
// Parallel-to-serial transmitter for a [D0][D1][D2] packed word, MSB (f=N-1) first.
// Optional even-parity trailer beat enabled by defining FLATTEN_SERIAL_PARITY_EN.
module flatten_three_serializer #(
  parameter int unsigned D0 = 3,
  parameter int unsigned D1 = 5,
  parameter int unsigned D2 = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           load,
  input  logic [D0-1:0][D1-1:0][D2-1:0]  data,
  input  logic                           hold,
  output logic                           ready,
  output logic                           out,
  output logic                           valid,
  output logic                           last,
  output logic                           busy
);

  localparam int unsigned N   = D0 * D1 * D2;
  localparam int unsigned CW  = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);
`ifdef FLATTEN_SERIAL_PARITY_EN
  localparam bit          PAR_EN = 1'b1;
`else
  localparam bit          PAR_EN = 1'b0;
`endif
  // Counter counts down to 0 on the final beat; the parity beat adds one step.
  localparam logic [CW-1:0] CNT_INIT = PAR_EN ? CW'(N) : CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        r_state;
  logic [N-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_par;
  logic          r_out;
  logic          r_valid;
  logic          r_last;

  logic [N-1:0]  w_flat;
  logic [N-1:0]  w_shl;
  logic          w_accept;

  assign w_flat   = data;
  assign w_shl    = r_shift << 1;
  assign ready    = !reset && ((r_state == IDLE) || (r_last && !hold));
  assign w_accept = load && ready;

  assign out   = r_out;
  assign valid = r_valid;
  assign last  = r_last;
  assign busy  = (r_state == SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= w_flat;
      r_cnt   <= CNT_INIT;
      r_par   <= ^w_flat;
      r_out   <= w_flat[N-1];
      r_valid <= 1'b1;
      r_last  <= (CNT_INIT == CW'(0));
    end else if ((r_state == SHIFT) && !hold) begin
      if (r_cnt == CW'(0)) begin
        r_state <= IDLE;
        r_shift <= '0;
        r_out   <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_cnt   <= r_cnt - CW'(1);
        r_shift <= w_shl;
        // Stepping onto count 0 with parity enabled means the trailer beat.
        r_out   <= (PAR_EN && (r_cnt == CW'(1))) ? r_par : w_shl[N-1];
        r_last  <= (r_cnt == CW'(1));
      end
    end
  end

endmodule
